// File: rtl/poly_operand_feeder.sv
// Operand feeder for the FIOS Montgomery multiplier: loads M'_0, A, B, M
// from a word stream, launches the multiplier and services its shifts.
module poly_operand_feeder #(
  parameter int s = 5,
  parameter int N = 5
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic           load_start_i,
  input  logic [16:0]    in_data_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  output logic [s*17-1:0] A_o,
  output logic [N*17-1:0] B_o,
  output logic [16:0]    M_prime_0_o,
  output logic [16:0]    M_o,
  input  logic           A_rot_i,
  input  logic           B_shift_i,
  input  logic           M_prime_0_rot_i,
  input  logic           M_shift_i,
  output logic           FIOS_start_o,
  input  logic           FIOS_done_i,
  output logic           busy_o,
  output logic           op_done_o
);

  localparam int W   = 17;
  localparam int TOT = 2*s + N + 1;
  localparam int CW  = $clog2(TOT);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, BUSY, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [s*W-1:0]  a_q;
  logic [N*W-1:0]  b_q;
  logic [s*W-1:0]  m_q;
  logic [W-1:0]    m0_q;
  logic            xfer;
  logic            busy_st;

  assign xfer    = in_ready_o & in_valid_i;
  assign busy_st = (state_q == BUSY);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    in_ready_o   = 1'b0;
    FIOS_start_o = 1'b0;
    op_done_o    = 1'b0;
    unique case (state_q)
      IDLE:  if (load_start_i) state_d = LOAD;
      LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i && cnt_q == CW'(TOT-1))
          state_d = START;
      end
      START: begin
        FIOS_start_o = 1'b1;
        state_d      = BUSY;
      end
      BUSY:  if (FIOS_done_i) state_d = DONE;
      DONE: begin
        op_done_o = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i)               cnt_q <= '0;
    else if (state_q == IDLE)   cnt_q <= '0;
    else if (xfer)              cnt_q <= cnt_q + 1'b1;
  end

  // Load writes and multiplier requests never overlap: LOAD vs BUSY.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      a_q  <= '0;
      b_q  <= '0;
      m_q  <= '0;
      m0_q <= '0;
    end else if (busy_st) begin
      if (A_rot_i)
        a_q <= {a_q[W-1:0], a_q[s*W-1:W]};
      if (B_shift_i)
        b_q <= b_q >> W;
      if (M_prime_0_rot_i)
        m0_q <= {m0_q[0], m0_q[W-1:1]};
      if (M_shift_i)
        m_q <= m_q >> W;
    end else if (xfer) begin
      unique case (1'b1)
        (cnt_q == '0):
          m0_q <= in_data_i;
        (cnt_q != '0 && cnt_q <= CW'(s)):
          for (int k = 0; k < s; k++)
            if (cnt_q == CW'(k+1))
              a_q[k*W +: W] <= in_data_i;
        (cnt_q > CW'(s) && cnt_q <= CW'(s+N)):
          for (int k = 0; k < N; k++)
            if (cnt_q == CW'(s+1+k))
              b_q[k*W +: W] <= in_data_i;
        (cnt_q > CW'(s+N)):
          for (int k = 0; k < s; k++)
            if (cnt_q == CW'(s+N+1+k))
              m_q[k*W +: W] <= in_data_i;
        default: ;
      endcase
    end
  end

  assign A_o         = a_q;
  assign B_o         = b_q;
  assign M_o         = m_q[W-1:0];
  assign M_prime_0_o = m0_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_poly_operand_feeder.sv
// Directed bench for poly_operand_feeder: load, start, shifts, done,
// ignored requests and asynchronous reset aborts.
module tb_poly_operand_feeder;

  localparam int S  = 5;
  localparam int NB = 5;

  logic            clock_i = 1'b0;
  logic            reset_i = 1'b0;
  logic            load_start_i = 1'b0;
  logic [16:0]     in_data_i = '0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [S*17-1:0] A_o;
  logic [NB*17-1:0] B_o;
  logic [16:0]     M_prime_0_o;
  logic [16:0]     M_o;
  logic            A_rot_i = 1'b0;
  logic            B_shift_i = 1'b0;
  logic            M_prime_0_rot_i = 1'b0;
  logic            M_shift_i = 1'b0;
  logic            FIOS_start_o;
  logic            FIOS_done_i = 1'b0;
  logic            busy_o;
  logic            op_done_o;

  int vecs  = 0;
  int fails = 0;

  poly_operand_feeder #(.s(S), .N(NB)) dut (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .load_start_i   (load_start_i),
    .in_data_i      (in_data_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .A_o            (A_o),
    .B_o            (B_o),
    .M_prime_0_o    (M_prime_0_o),
    .M_o            (M_o),
    .A_rot_i        (A_rot_i),
    .B_shift_i      (B_shift_i),
    .M_prime_0_rot_i(M_prime_0_rot_i),
    .M_shift_i      (M_shift_i),
    .FIOS_start_o   (FIOS_start_o),
    .FIOS_done_i    (FIOS_done_i),
    .busy_o         (busy_o),
    .op_done_o      (op_done_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input bit gap, input int base,
                      output int xfers, output int starts);
    int idx;
    int cyc;
    bit take;
    idx = 0; cyc = 0; xfers = 0; starts = 0;
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    chk("ready_after_start", in_ready_o, 1'b1);
    while (idx < n && cyc < 200) begin
      in_valid_i = gap ? (cyc % 2 == 1) : 1'b1;
      in_data_i  = in_valid_i ? 17'(base + idx) : 17'h1FFFF;
      take = in_valid_i && in_ready_o;
      tick();
      cyc++;
      starts += int'(FIOS_start_o);
      if (take) begin
        idx++;
        xfers++;
        if (idx == 1) chk("word0_visible", M_prime_0_o, 17'(base));
      end
    end
    in_valid_i = 1'b0;
    chk("load_budget", idx, n);
  endtask

  task automatic check_regs(input string tag, input int base);
    logic [S*17-1:0]  ea;
    logic [NB*17-1:0] eb;
    for (int k = 0; k < S; k++)  ea[k*17 +: 17] = 17'(base + 1 + k);
    for (int k = 0; k < NB; k++) eb[k*17 +: 17] = 17'(base + 1 + S + k);
    chk({tag, "_M0"}, M_prime_0_o, 17'(base));
    chk({tag, "_A"}, A_o, ea);
    chk({tag, "_B"}, B_o, eb);
    chk({tag, "_M"}, M_o, 17'(base + 1 + S + NB));
  endtask

  initial begin
    int xf;
    int st;
    int arot[5];
    int msh[5];
    arot = '{3, 4, 5, 6, 2};
    msh  = '{13, 14, 15, 16, 0};

    // reset state
    #12;
    chk("rst_ready", in_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_start", FIOS_start_o, 1'b0);
    chk("rst_done", op_done_o, 1'b0);
    chk("rst_A", A_o, '0);
    chk("rst_M0", M_prime_0_o, '0);
    reset_i = 1'b1;
    tick();

    // continuous load of words 1..16
    load(16, 1'b0, 1, xf, st);
    chk("l1_start_pulse", FIOS_start_o, 1'b1);
    chk("l1_ready_low", in_ready_o, 1'b0);
    chk("l1_busy", busy_o, 1'b1);
    check_regs("l1", 1);
    tick();
    chk("l1_start_end", FIOS_start_o, 1'b0);
    chk("l1_starts", st, 1);

    // A rotate held five cycles
    A_rot_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("arot_w0", A_o[16:0], 17'(arot[i]));
    end
    A_rot_i = 1'b0;
    chk("arot_full", A_o, {17'd6, 17'd5, 17'd4, 17'd3, 17'd2});

    // M shift held five cycles
    M_shift_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mshift", M_o, 17'(msh[i]));
    end
    M_shift_i = 1'b0;

    // load_start while busy is ignored
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    chk("ls_busy_ready", in_ready_o, 1'b0);
    chk("ls_busy_busy", busy_o, 1'b1);

    // done together with an A rotate
    FIOS_done_i = 1'b1;
    A_rot_i     = 1'b1;
    tick();
    FIOS_done_i = 1'b0;
    A_rot_i     = 1'b0;
    chk("done_pulse", op_done_o, 1'b1);
    chk("done_busy", busy_o, 1'b1);
    chk("done_arot", A_o[16:0], 17'd3);
    tick();
    chk("done_end", op_done_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);

    // requests in IDLE are ignored
    A_rot_i = 1'b1; B_shift_i = 1'b1; M_prime_0_rot_i = 1'b1;
    M_shift_i = 1'b1; FIOS_done_i = 1'b1; in_valid_i = 1'b1;
    in_data_i = 17'h1ABCD;
    tick();
    tick();
    A_rot_i = 1'b0; B_shift_i = 1'b0; M_prime_0_rot_i = 1'b0;
    M_shift_i = 1'b0; FIOS_done_i = 1'b0; in_valid_i = 1'b0;
    chk("idle_A", A_o, {17'd2, 17'd6, 17'd5, 17'd4, 17'd3});
    chk("idle_B", B_o, {17'd11, 17'd10, 17'd9, 17'd8, 17'd7});
    chk("idle_M0", M_prime_0_o, 17'd1);
    chk("idle_busy2", busy_o, 1'b0);
    chk("idle_opdone", op_done_o, 1'b0);

    // gapped load
    load(16, 1'b1, 1, xf, st);
    chk("l2_start_pulse", FIOS_start_o, 1'b1);
    check_regs("l2", 1);
    tick();
    chk("l2_xfers", xf, 16);
    chk("l2_starts", st, 1);
    chk("l2_start_end", FIOS_start_o, 1'b0);

    // simultaneous requests
    A_rot_i = 1'b1; B_shift_i = 1'b1; M_prime_0_rot_i = 1'b1;
    tick();
    A_rot_i = 1'b0; B_shift_i = 1'b0; M_prime_0_rot_i = 1'b0;
    chk("sim_M0", M_prime_0_o, 17'h10000);
    chk("sim_A", A_o, {17'd2, 17'd6, 17'd5, 17'd4, 17'd3});
    chk("sim_B", B_o, {17'd0, 17'd11, 17'd10, 17'd9, 17'd8});
    chk("sim_M", M_o, 17'd12);

    // asynchronous reset while busy
    #2;
    reset_i = 1'b0;
    #1;
    chk("rb_busy", busy_o, 1'b0);
    chk("rb_A", A_o, '0);
    chk("rb_B", B_o, '0);
    chk("rb_M0", M_prime_0_o, '0);
    chk("rb_opdone", op_done_o, 1'b0);
    reset_i = 1'b1;
    tick();

    // asynchronous reset after word 8 of a load
    load(8, 1'b0, 1, xf, st);
    chk("rl_M0_before", M_prime_0_o, 17'd1);
    #2;
    reset_i = 1'b0;
    #1;
    chk("rl_ready", in_ready_o, 1'b0);
    chk("rl_busy", busy_o, 1'b0);
    chk("rl_A", A_o, '0);
    chk("rl_M0", M_prime_0_o, '0);
    reset_i = 1'b1;
    tick();

    // fresh full load completes normally
    load(16, 1'b0, 20, xf, st);
    chk("l3_start_pulse", FIOS_start_o, 1'b1);
    check_regs("l3", 20);
    tick();
    chk("l3_busy", busy_o, 1'b1);
    FIOS_done_i = 1'b1;
    tick();
    FIOS_done_i = 1'b0;
    chk("l3_done", op_done_o, 1'b1);
    tick();
    chk("l3_done_end", op_done_o, 1'b0);
    chk("l3_idle", busy_o, 1'b0);
    chk("l3_hold_A", A_o, {17'd25, 17'd24, 17'd23, 17'd22, 17'd21});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
